imem_bootload: RTL and testbench
================================

# imem_bootload

Parametrised instruction memory for the simpu data path. It serves single-word fetch requests through a valid/ready handshake with one-cycle registered read latency, and accepts run-time writes from the loader port. After reset, or on request, a boot sequencer copies a fixed boot program from a package constant table into the array, one word per cycle. The block sits between the fetch stage (PC → instruction) and the program loader.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 16, address width of the fetch and write ports
- DEPTH, 256, number of words; must be ≤ 2**ADDR_W
- BOOT_LEN, 8, boot-table words copied to addresses 0..BOOT_LEN-1; must be ≤ DEPTH
---
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  word address to fetch
- fetch_ready  out  1  block can accept a fetch this cycle
- fetch_valid  out  1  fetch_data/fetch_err are valid (one-cycle pulse per accepted fetch)
- fetch_data  out  DATA_W  fetched word
- fetch_err  out  1  accepted fetch address was ≥ DEPTH
- wr_en  in  1  loader write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  write accepted (registered, one cycle after wr_en)
- reload  in  1  single-cycle pulse that re-runs the boot copy
- busy  out  1  boot sequencer active

## Operation
- FSM states: BOOT and RUN. Reset enters BOOT with boot counter = 0.
- BOOT: each cycle writes BOOT_TABLE[cnt] to mem[cnt] and increments cnt. When cnt == BOOT_LEN-1 is written, the next state is RUN. busy=1 and fetch_ready=0 throughout. wr_en and fetch_req are ignored (no ack, no valid).
- RUN: fetch_ready=1 and busy=0.
- Fetch: the handshake fires when fetch_req && fetch_ready.
  - Next cycle: fetch_valid=1 and fetch_data=mem[fetch_addr].
  - If fetch_addr ≥ DEPTH: fetch_data=0 and fetch_err=1.
  - Back-to-back fetches are accepted every cycle.
- Write (RUN only): wr_en writes mem[wr_addr]. wr_ack=1 the next cycle.
  - Out-of-range wr_addr (≥ DEPTH): array untouched, wr_ack still asserted.
- Same-cycle fetch and write to the same address: the fetch returns the old word (read-first).
- reload in RUN: next state is BOOT with cnt=0. A fetch or write in the same cycle as reload is still served (valid/ack next cycle). reload during BOOT is ignored.
- Only words 0..BOOT_LEN-1 are rewritten by the boot copy. Other words keep their contents across reload. After power-up their contents are undefined; no clear is required.

## Timing
- Reset values (async assert): state=BOOT, cnt=0, fetch_valid=0, fetch_err=0, fetch_data=0, wr_ack=0, busy=1, fetch_ready=0.
- Array contents are not reset (no async reset on the memory).
- After reset deassertion, boot takes BOOT_LEN cycles. The first fetch is accepted in cycle BOOT_LEN+1 after the first clock edge.
- Fetch latency: 1 cycle. Write-to-read visibility: a fetch accepted the cycle after a write sees the new data.
- Reset asserted mid-boot or mid-fetch: the in-flight fetch_valid is dropped and the boot restarts from 0.
- fetch_ready and busy are combinational decodes of state only, never of inputs.

## Structure
- Package imem_pkg holds:
  - the state enum (BOOT, RUN);
  - BOOT_TABLE, the 8-word default program: 0x7042000A, 0x70820004, 0xB0400000, 0xB0800002, 0x60400000, 0x70820002, 0x58C41000, 0xB0C00004.
- One sub-module, imem_ram: a DEPTH×DATA_W single-port-write, registered-read array without reset.
- The top level holds the FSM, counter, address range checks and the write mux (boot vs loader).

## Test plan
- Reset release, then fetch addr 0..7 back-to-back → busy low after 8 cycles; data equals BOOT_TABLE in order, each with fetch_valid one cycle after the request and fetch_err=0.
- Write 0xDEADBEEF to addr 200, then fetch addr 200 the next cycle → wr_ack=1 in the following cycle; fetch_data=0xDEADBEEF.
- Same cycle: write 0x12345678 to addr 3 and fetch addr 3 → fetch returns 0xB0800002; a fetch on the next cycle returns 0x12345678.
- Fetch addr 300 and write addr 300 (DEPTH=256) → fetch_err=1 with fetch_data=0; wr_ack=1; fetch addr 44 (300 mod 256) is unchanged.
- Overwrite addr 1 and addr 100, then pulse reload → busy for 8 cycles, during which fetch_req gets no valid; afterwards addr 1 = 0x70820004 and addr 100 keeps the written value.
- Assert reset during boot cycle 4 and during an accepted fetch → fetch_valid falls immediately; after release the full 8-cycle boot repeats and the table is correct.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and the default boot program for the instruction memory.
package imem_pkg;

  typedef enum logic {BOOT, RUN} state_t;

  localparam int BOOT_TABLE_LEN = 8;

  localparam logic [31:0] BOOT_TABLE [BOOT_TABLE_LEN] = '{
    32'h7042000A, 32'h70820004, 32'hB0400000, 32'hB0800002,
    32'h60400000, 32'h70820002, 32'h58C41000, 32'hB0C00004
  };

  // Entries past the table read as zero so a longer BOOT_LEN stays defined.
  function automatic logic [31:0] boot_word(input int unsigned idx);
    return (idx < BOOT_TABLE_LEN) ? BOOT_TABLE[idx] : 32'h0;
  endfunction

endpackage

// File: rtl/imem_bootload_if.sv
// Fetch, loader-write and boot-control signals of the instruction memory.
interface imem_bootload_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              reload;
  logic              busy;

  modport master (
    output fetch_req, fetch_addr, wr_en, wr_addr, wr_data, reload,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err, wr_ack, busy
  );

  modport slave (
    input  fetch_req, fetch_addr, wr_en, wr_addr, wr_data, reload,
    output fetch_ready, fetch_valid, fetch_data, fetch_err, wr_ack, busy
  );
endinterface

// File: rtl/imem_ram.sv
// Single write port, registered read port array; contents are never reset.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Read and write share one edge, so a colliding read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_bootload.sv
// Instruction memory with boot-copy sequencer, fetch port and loader write port.
module imem_bootload
  import imem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 256,
  parameter int BOOT_LEN = 8
) (
  input  logic            clk,
  input  logic            reset,
  imem_bootload_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              fire, f_in_range, w_in_range;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  logic              vld_q, err_q, ack_q;

  // One extra bit keeps the compare correct when DEPTH == 2**ADDR_W.
  assign f_in_range = {1'b0, bus.fetch_addr} < DEPTH_EXT;
  assign w_in_range = {1'b0, bus.wr_addr} < DEPTH_EXT;

  assign bus.fetch_ready = (state == RUN);
  assign bus.busy        = (state == BOOT);
  assign fire            = bus.fetch_req && bus.fetch_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ram_we    = 1'b0;
    ram_waddr = bus.wr_addr[AW-1:0];
    ram_wdata = bus.wr_data;
    unique case (state)
      BOOT: begin
        ram_we    = 1'b1;
        ram_waddr = AW'(cnt);
        ram_wdata = DATA_W'(boot_word(32'(cnt)));
        if (cnt == CW'(BOOT_LEN - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        ram_we = bus.wr_en && w_in_range;
        if (bus.reload) begin
          state_nxt = BOOT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      cnt   <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      vld_q <= fire;
      err_q <= fire && !f_in_range;
      ack_q <= bus.wr_en && (state == RUN);
    end
  end

  imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (fire && f_in_range),
    .raddr (bus.fetch_addr[AW-1:0]),
    .rdata (ram_q)
  );

  // The array read register has no reset, so data is forced to zero outside a good fetch.
  assign bus.fetch_data  = (vld_q && !err_q) ? ram_q : '0;
  assign bus.fetch_valid = vld_q;
  assign bus.fetch_err   = err_q;
  assign bus.wr_ack      = ack_q;
endmodule

// File: tb/tb_imem_bootload.sv
// Randomized bench for imem_bootload against a word-level memory model.
module tb_imem_bootload;
  localparam int DATA_W = 32, ADDR_W = 16, DEPTH = 256, BOOT_LEN = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imem_bootload_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_bootload #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BOOT_LEN(BOOT_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] tbl [8] = '{
    32'h7042000A, 32'h70820004, 32'hB0400000, 32'hB0800002,
    32'h60400000, 32'h70820002, 32'h58C41000, 32'hB0C00004
  };

  // Model: word array plus "known" flags (untouched words are undefined),
  // and the number of cycles the memory remains unavailable for boot.
  logic [31:0] mmem  [DEPTH];
  bit          known [DEPTH];
  int          boot_left;
  int          vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_boot();
    for (int i = 0; i < BOOT_LEN; i++) begin
      mmem[i]  = tbl[i];
      known[i] = 1'b1;
    end
    boot_left = BOOT_LEN;
  endtask

  task automatic idle_inputs();
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.reload     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    chk("rst_valid", 32'(bus.fetch_valid), 0);
    chk("rst_err",   32'(bus.fetch_err), 0);
    chk("rst_data",  bus.fetch_data, 0);
    chk("rst_ack",   32'(bus.wr_ack), 0);
    chk("rst_busy",  32'(bus.busy), 1);
    chk("rst_ready", 32'(bus.fetch_ready), 0);
    @(negedge clk);
    reset = 1'b1;
    load_boot();
  endtask

  // One clock: check state-decoded outputs, drive inputs, predict, clock, check responses.
  task automatic cycle(input bit req, input logic [15:0] fa, input bit we,
                       input logic [15:0] wa, input logic [31:0] wd, input bit rel);
    bit booting;
    bit n_valid, n_err, n_ack, n_dchk;
    logic [31:0] n_data;
    booting = (boot_left > 0);
    chk("busy",  32'(bus.busy), 32'(booting));
    chk("ready", 32'(bus.fetch_ready), 32'(!booting));
    bus.fetch_req  = req;
    bus.fetch_addr = fa;
    bus.wr_en      = we;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.reload     = rel;
    n_valid = 0; n_err = 0; n_ack = 0; n_dchk = 1; n_data = '0;
    if (booting) begin
      boot_left--;
    end else begin
      if (req) begin
        n_valid = 1;
        if (fa >= DEPTH) n_err = 1;
        else begin
          n_data = mmem[fa];
          n_dchk = known[fa];
        end
      end
      if (we) begin
        n_ack = 1;
        if (wa < DEPTH) begin
          mmem[wa]  = wd;
          known[wa] = 1'b1;
        end
      end
      if (rel) load_boot();
    end
    @(posedge clk); #1;
    chk("valid", 32'(bus.fetch_valid), 32'(n_valid));
    chk("ack",   32'(bus.wr_ack), 32'(n_ack));
    if (n_valid) begin
      chk("err", 32'(bus.fetch_err), 32'(n_err));
      if (n_dchk) chk("data", bus.fetch_data, n_data);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)      return 16'($urandom_range(0, 15));
    else if (r < 9) return 16'($urandom_range(0, DEPTH - 1));
    else            return 16'($urandom_range(DEPTH, 1023));
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    boot_left = BOOT_LEN;
    idle_inputs();
    #17;
    do_reset();

    // Fetches during boot are ignored; then the boot table comes back in order.
    for (int i = 0; i < BOOT_LEN; i++) cycle(1, 16'(i), 0, 0, 0, 0);
    for (int i = 0; i < BOOT_LEN; i++) cycle(1, 16'(i), 0, 0, 0, 0);

    // Write then read-after-write.
    cycle(0, 0, 1, 16'd200, 32'hDEADBEEF, 0);
    cycle(1, 16'd200, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Same-cycle collision is read-first.
    cycle(1, 16'd3, 1, 16'd3, 32'h12345678, 0);
    cycle(1, 16'd3, 0, 0, 0, 0);

    // Out-of-range fetch and write; the aliased word stays unchanged.
    cycle(0, 0, 1, 16'd44, 32'h44444444, 0);
    cycle(1, 16'd300, 1, 16'd300, 32'hCAFEF00D, 0);
    cycle(1, 16'd44, 0, 0, 0, 0);

    // Reload restores only the boot region.
    cycle(0, 0, 1, 16'd1, 32'h11111111, 0);
    cycle(0, 0, 1, 16'd100, 32'h10010010, 0);
    cycle(1, 16'd1, 0, 0, 0, 1);
    for (int i = 0; i < BOOT_LEN; i++) cycle(1, 16'(i), 1, 16'd100, 32'hBAD0BAD0, 1);
    cycle(1, 16'd1, 0, 0, 0, 0);
    cycle(1, 16'd100, 0, 0, 0, 0);

    // Reset in boot cycle 4.
    cycle(1, 16'd100, 1, 16'd1, 32'h22222222, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("midboot_busy", 32'(bus.busy), 1);
    do_reset();
    for (int i = 0; i < BOOT_LEN; i++) cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < BOOT_LEN; i++) cycle(1, 16'(i), 0, 0, 0, 0);

    // Reset while a fetch response is on the bus.
    cycle(1, 16'd5, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("midfetch_valid", 32'(bus.fetch_valid), 0);
    do_reset();
    for (int i = 0; i < BOOT_LEN; i++) cycle(0, 0, 0, 0, 0, 0);

    // Random traffic with occasional reloads.
    for (int n = 0; n < 600; n++) begin
      cycle(bit'($urandom_range(0, 1)), pick_addr(),
            ($urandom_range(0, 2) == 0), pick_addr(), $urandom,
            ($urandom_range(0, 39) == 0));
    end
    idle_inputs();
    for (int i = 0; i < BOOT_LEN + 2; i++) cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < BOOT_LEN; i++) cycle(1, 16'(i), 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
